// File: rtl/router_out_port_allocator.sv
// Output-port scheduler for one router output direction: owns the two output VCs
// packet-by-packet, grants one flit per cycle round-robin and tracks downstream credits.
module router_out_port_allocator #(
    parameter int NUM_IN  = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] req_vc,
    input  logic [NUM_IN-1:0] req_head,
    input  logic [NUM_IN-1:0] req_tail,
    input  logic [1:0]        credit_in,
    output logic [NUM_IN-1:0] gnt,
    output logic [2:0]        osel,
    output logic              ovalid,
    output logic              ovch,
    output logic [1:0]        vc_busy,
    output logic [2*CW-1:0]   credit_cnt,
    output logic              err
);

    logic [1:0]         vc_owned_reg;
    logic [1:0][2:0]    owner_reg;
    logic [2:0]         rr_reg;
    logic [1:0][CW-1:0] cnt_reg;
    logic [1:0][CW-1:0] cnt_next;
    logic [2:0]         osel_reg;
    logic               ovalid_reg;
    logic               ovch_reg;
    logic               err_reg;

    logic [NUM_IN-1:0]  elig;
    logic [NUM_IN-1:0]  proto_err;
    logic [1:0]         send;
    logic [1:0]         cred_ovf;
    logic               win_valid;
    logic [2:0]         win_idx;
    logic               win_vc;
    logic               err_next;

    // Per-input eligibility and protocol checks against the VC each flit targets.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            logic v;
            logic own_hit;
            assign v         = req_vc[gi];
            assign own_hit   = vc_owned_reg[v] && (owner_reg[v] == 3'(gi));
            assign elig[gi]  = req[gi] && (cnt_reg[v] != '0) &&
                               (req_head[gi] ? !vc_owned_reg[v] : own_hit);
            assign proto_err[gi] = req[gi] && (req_head[gi] ? own_hit : !vc_owned_reg[v]);
        end
    endgenerate

    // Round-robin scan starting at the pointer; reset forces no grant.
    always_comb begin
        int idx;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!win_valid && elig[idx]) begin
                win_valid = 1'b1;
                win_idx   = 3'(idx);
            end
        end
        if (rst) win_valid = 1'b0;
        gnt = '0;
        if (win_valid) gnt[win_idx] = 1'b1;
    end

    assign win_vc = req_vc[win_idx];

    // A return that would overflow a full counter is dropped and flagged.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            assign send[gi]     = win_valid && (win_vc == 1'(gi));
            assign cred_ovf[gi] = credit_in[gi] && !send[gi] && (cnt_reg[gi] == CW'(CREDITS));
            assign cnt_next[gi] = cred_ovf[gi] ? cnt_reg[gi]
                                : cnt_reg[gi] - CW'(send[gi]) + CW'(credit_in[gi]);
        end
    endgenerate

    assign err_next = err_reg | (|proto_err) | (|cred_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc_owned_reg <= '0;
            owner_reg    <= '0;
            rr_reg       <= '0;
            cnt_reg      <= {2{CW'(CREDITS)}};
            osel_reg     <= '0;
            ovalid_reg   <= 1'b0;
            ovch_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (win_valid) begin
                if (req_tail[win_idx]) begin
                    vc_owned_reg[win_vc] <= 1'b0;
                end else if (req_head[win_idx]) begin
                    vc_owned_reg[win_vc] <= 1'b1;
                    owner_reg[win_vc]    <= win_idx;
                end
                rr_reg   <= (win_idx == 3'(NUM_IN - 1)) ? 3'd0 : win_idx + 3'd1;
                osel_reg <= win_idx;
                ovch_reg <= win_vc;
            end
            ovalid_reg <= win_valid;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
        end
    end

    assign osel       = osel_reg;
    assign ovalid     = ovalid_reg;
    assign ovch       = ovch_reg;
    assign vc_busy    = vc_owned_reg;
    assign credit_cnt = cnt_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_router_out_port_allocator.sv
// Directed bench for router_out_port_allocator: reset, round-robin, VC ownership,
// credit stall/return, protocol errors and mid-packet reset.
module tb_router_out_port_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req, req_vc, req_head, req_tail;
    logic [1:0] credit_in;
    logic [4:0] gnt;
    logic [2:0] osel;
    logic       ovalid, ovch, err;
    logic [1:0] vc_busy;
    logic [5:0] credit_cnt;

    int n_total = 0;
    int n_pass  = 0;

    router_out_port_allocator #(.NUM_IN(5), .CREDITS(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_vc(req_vc), .req_head(req_head),
        .req_tail(req_tail), .credit_in(credit_in), .gnt(gnt), .osel(osel),
        .ovalid(ovalid), .ovch(ovch), .vc_busy(vc_busy), .credit_cnt(credit_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [4:0] r, input logic [4:0] v, input logic [4:0] h,
                       input logic [4:0] t, input logic [1:0] c);
        req = r; req_vc = v; req_head = h; req_tail = t; credit_in = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    initial begin
        rst = 1'b1;
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        tick(); tick();

        // 1. reset with every input requesting
        set(5'h1F, 5'h00, 5'h1F, 5'h1F, 2'b00);
        #1;
        chk("rst_gnt", gnt, 5'h00);
        chk("rst_ovalid", ovalid, 1'b0);
        chk("rst_busy", vc_busy, 2'b00);
        chk("rst_credits", credit_cnt, 6'h24);
        chk("rst_err", err, 1'b0);
        chk("rst_osel", osel, 3'd0);
        tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        rst = 1'b0;
        tick();

        // 2. round-robin among inputs 0,2,4 with credits refilled every cycle
        set(5'h15, 5'h00, 5'h15, 5'h15, 2'b01);
        #1; chk("rr_gnt0", gnt, 5'h01);
        tick(); chk("rr_osel0", osel, 3'd0); chk("rr_ovalid", ovalid, 1'b1); chk("rr_ovch", ovch, 1'b0);
        #1; chk("rr_gnt1", gnt, 5'h04);
        tick(); chk("rr_osel1", osel, 3'd2);
        #1; chk("rr_gnt2", gnt, 5'h10);
        tick(); chk("rr_osel2", osel, 3'd4);
        #1; chk("rr_gnt3", gnt, 5'h01);
        tick(); chk("rr_osel3", osel, 3'd0);
        chk("rr_credits", credit_cnt, 6'h24);
        chk("rr_err", err, 1'b0);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        tick(); chk("idle_ovalid", ovalid, 1'b0);

        // 3. input 1 owns VC1 for 3 flits; input 3 waits; input 2 interleaves on VC0 (rr=1)
        set(5'h0E, 5'h0A, 5'h0E, 5'h0C, 2'b00);
        #1; chk("own_gnt_h", gnt, 5'h02);
        tick(); chk("own_busy", vc_busy, 2'b10); chk("own_osel", osel, 3'd1); chk("own_ovch", ovch, 1'b1);
        set(5'h0E, 5'h0A, 5'h0C, 5'h0C, 2'b00);
        #1; chk("own_gnt_i2a", gnt, 5'h04);
        tick(); chk("own_ovch0", ovch, 1'b0);
        #1; chk("own_gnt_b", gnt, 5'h02);
        tick();
        set(5'h0E, 5'h0A, 5'h0C, 5'h0E, 2'b00);
        #1; chk("own_gnt_i2b", gnt, 5'h04);
        tick();
        #1; chk("own_gnt_t", gnt, 5'h02);
        tick(); chk("own_free", vc_busy, 2'b00);
        set(5'h08, 5'h0A, 5'h08, 5'h08, 2'b00);
        #1; chk("own_gnt_i3", gnt, 5'h08);
        tick(); chk("own_osel3", osel, 3'd3); chk("own_credits", credit_cnt, 6'h02);
        chk("own_err", err, 1'b0);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b11);
        tick(); tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b10);
        tick(); tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        chk("refill_credits", credit_cnt, 6'h24);
        chk("refill_err", err, 1'b0);

        // 4. credit exhaustion on VC0, then a single return (rr=4)
        set(5'h01, 5'h00, 5'h01, 5'h01, 2'b00);
        for (int i = 0; i < 4; i++) begin
            #1; chk($sformatf("cr_gnt%0d", i), gnt, 5'h01);
            tick();
        end
        chk("cr_empty", credit_cnt, 6'h20);
        #1; chk("cr_stall", gnt, 5'h00);
        tick(); chk("cr_ovalid0", ovalid, 1'b0);
        set(5'h01, 5'h00, 5'h01, 5'h01, 2'b01);
        #1; chk("cr_same_cyc", gnt, 5'h00);
        tick();
        set(5'h01, 5'h00, 5'h01, 5'h01, 2'b00);
        chk("cr_one", credit_cnt, 6'h21);
        #1; chk("cr_gnt_ret", gnt, 5'h01);
        tick(); chk("cr_ovalid1", ovalid, 1'b1); chk("cr_empty2", credit_cnt, 6'h20);
        #1; chk("cr_stall2", gnt, 5'h00);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b01);
        tick(); tick(); tick(); tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        chk("cr_refill", credit_cnt, 6'h24);
        chk("cr_err", err, 1'b0);

        // 5. protocol errors
        set(5'h04, 5'h00, 5'h00, 5'h00, 2'b00);
        #1; chk("err_body_gnt", gnt, 5'h00);
        tick(); chk("err_body", err, 1'b1); chk("err_body_ov", ovalid, 1'b0);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        rst = 1'b1;
        #1; chk("err_rst_clr", err, 1'b0);
        tick(); rst = 1'b0;
        tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b10);
        tick();
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        chk("err_ovf_cnt", credit_cnt, 6'h24);
        chk("err_ovf", err, 1'b1);

        // 6. reset in the middle of a packet
        rst = 1'b1;
        tick(); rst = 1'b0;
        set(5'h01, 5'h00, 5'h01, 5'h00, 2'b00);
        #1; chk("mid_gnt", gnt, 5'h01);
        tick(); chk("mid_busy", vc_busy, 2'b01);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", vc_busy, 2'b00);
        chk("mid_rst_cred", credit_cnt, 6'h24);
        chk("mid_rst_ov", ovalid, 1'b0);
        tick();
        rst = 1'b0;
        set(5'h10, 5'h00, 5'h10, 5'h00, 2'b00);
        #1; chk("mid_new_gnt", gnt, 5'h10);
        tick();
        chk("mid_new_busy", vc_busy, 2'b01);
        chk("mid_new_osel", osel, 3'd4);
        chk("mid_new_ov", ovalid, 1'b1);
        chk("mid_new_cred", credit_cnt, 6'h23);
        chk("mid_new_err", err, 1'b0);
        set(5'h00, 5'h00, 5'h00, 5'h00, 2'b00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
